// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the fetch/decode pipeline register: bubble constants and
// the per-edge update priority used by the stage and by hazard-unit assertions.
package pipe_stage_reg_pkg;

   localparam int unsigned NOP_INSTR = 0;
   localparam int unsigned BUBBLE_PC = 0;

   // Highest priority first.
   typedef enum logic [2:0] {
      PrioReset = 3'd0,
      PrioFlush = 3'd1,
      PrioStall = 3'd2,
      PrioAnnul = 3'd3,
      PrioLoad  = 3'd4
   } prio_e;

   function automatic prio_e pick_prio(input logic reset_n, input logic flush,
                                       input logic stall, input logic annul);
      if (!reset_n)    return PrioReset;
      else if (flush)  return PrioFlush;
      else if (stall)  return PrioStall;
      else if (annul)  return PrioAnnul;
      else             return PrioLoad;
   endfunction

endpackage

// File: rtl/pipe_stage_reg_sat.sv
// Saturating up-counter with synchronous clear and synchronous active-low reset.
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (inc && (r_cnt != {W{1'b1}})) begin
         r_cnt <= r_cnt + W'(1);
      end
   end

   assign cnt = r_cnt;

endmodule

// File: rtl/pipe_stage_reg.sv
// IF/ID pipeline register with flush, stall hold, delay-slot annul, saturating
// stall/bubble counters and a sticky consecutive-stall watchdog.
module pipe_stage_reg
   import pipe_stage_reg_pkg::*;
#(
   parameter int unsigned   IW        = 32,
   parameter int unsigned   AW        = 32,
   parameter logic [AW-1:0] RESET_PC  = '0,
   parameter int unsigned   CNT_W     = 16,
   parameter int unsigned   STALL_MAX = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [IW-1:0]    in_instr,
   input  logic [AW-1:0]    in_pc,
   input  logic             in_valid,
   input  logic             stall,
   input  logic             flush,
   input  logic             annul,
   input  logic             cnt_clr,
   output logic [IW-1:0]    out_instr,
   output logic [AW-1:0]    out_pc,
   output logic [AW-1:0]    out_pc8,
   output logic             out_valid,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] bubble_cnt,
   output logic             stall_timeout
);

   localparam logic [CNT_W-1:0] TripVal = CNT_W'(STALL_MAX - 1);

   logic [IW-1:0]    r_instr;
   logic [AW-1:0]    r_pc;
   logic [AW-1:0]    r_pc8;
   logic             r_valid;
   logic             r_timeout;
   logic [CNT_W-1:0] w_run_cnt;
   prio_e            w_prio;
   logic             w_stall_eff;
   logic             w_bubble;

   assign w_prio      = pick_prio(reset, flush, stall, annul);
   assign w_stall_eff = (w_prio == PrioStall);
   assign w_bubble    = (w_prio == PrioFlush) || (w_prio == PrioAnnul);

   always_ff @(posedge clk) begin
      unique case (w_prio)
         PrioReset: begin
            r_instr <= '0;
            r_pc    <= RESET_PC;
            r_pc8   <= RESET_PC + AW'(8);
            r_valid <= 1'b0;
         end
         PrioFlush, PrioAnnul: begin
            r_instr <= IW'(NOP_INSTR);
            r_pc    <= AW'(BUBBLE_PC);
            r_pc8   <= AW'(BUBBLE_PC);
            r_valid <= 1'b0;
         end
         PrioStall: begin
            r_instr <= r_instr;
            r_pc    <= r_pc;
            r_pc8   <= r_pc8;
            r_valid <= r_valid;
         end
         default: begin
            r_instr <= in_instr;
            r_pc    <= in_pc;
            r_pc8   <= in_pc + AW'(8);
            r_valid <= in_valid;
         end
      endcase
   end

   // Sets on the stall edge that brings the run to STALL_MAX; cnt_clr wins.
   always_ff @(posedge clk) begin
      if (!reset || flush || cnt_clr) begin
         r_timeout <= 1'b0;
      end else if (w_stall_eff && (w_run_cnt == TripVal)) begin
         r_timeout <= 1'b1;
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (w_stall_eff),
      .clr   (cnt_clr),
      .cnt   (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_bubble_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (w_bubble),
      .clr   (cnt_clr),
      .cnt   (bubble_cnt)
   );

   sat_counter #(.W(CNT_W)) u_run_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (w_stall_eff),
      .clr   (!w_stall_eff),
      .cnt   (w_run_cnt)
   );

   assign out_instr     = r_instr;
   assign out_pc        = r_pc;
   assign out_pc8       = r_pc8;
   assign out_valid     = r_valid;
   assign stall_timeout = r_timeout;

endmodule
